// File: rtl/enc_pkg.sv
// Shared types, constants and helpers for the PmodENC front end.
package enc_pkg;

  // Quadrature state packed as {A, B}.
  typedef logic [1:0] quad_t;

  // Controller: hold everything quiet after reset, then decode.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // 10 us and 5 ms at 100 MHz.
  localparam int unsigned QUAD_FILTER_DEFAULT = 1000;
  localparam int unsigned DEBOUNCE_DEFAULT    = 500000;

  // Index of a quad state along the CW Gray sequence 00->10->11->01.
  // A difference of +1 (mod 4) between two indices is a CW edge.
  function automatic logic [1:0] quad_pos(input quad_t q);
    logic [1:0] pos;
    case (q)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a stability filter. The accepted level
// only follows the synchronized input after it has differed for N cycles.
module sync_filter #(
  parameter int unsigned N         = 4,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,    // raw asynchronous input
  input  logic run_i,    // filtering active
  input  logic load_i,   // take synchronized value directly, no strobe
  output logic level_o,  // accepted level
  output logic chg_o     // high for the cycle the accepted level has just changed
);

  localparam int unsigned      CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  logic             meta_q, sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             chg_q, chg_d;

  // Synchronizer chain for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
    end
  end

  // Stability counter: clears while input matches, accepts at N-1.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    chg_d   = 1'b0;
    if (load_i) begin
      level_d = sync_q;
    end else if (run_i && (sync_q != level_q)) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
        chg_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      chg_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      chg_q   <= chg_d;
    end
  end

  assign level_o = level_q;
  assign chg_o   = chg_q;

endmodule

// File: rtl/rotary_encoder_decoder.sv
// PmodENC front end: filtered inputs, quadrature detent counter with step
// pulses and sticky error, debounced button/switch with button-press pulse.
module rotary_encoder_decoder
  import enc_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH        = 16,
  parameter int unsigned EDGES_PER_STEP     = 4,
  parameter int unsigned QUAD_FILTER_CYCLES = QUAD_FILTER_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES    = DEBOUNCE_DEFAULT
) (
  input  logic                   clk_100MHz,
  input  logic                   resetn,
  input  logic                   encA,
  input  logic                   encB,
  input  logic                   encBTN,
  input  logic                   encSWT,
  input  logic                   clr_count,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   step_cw,
  output logic                   step_ccw,
  output logic                   dir,
  output logic                   btn_level,
  output logic                   btn_press,
  output logic                   swt_level,
  output logic                   err
);

  localparam logic signed [3:0] ACC_POS = 4'(EDGES_PER_STEP);
  localparam logic signed [3:0] ACC_NEG = -ACC_POS;

  ctrl_state_e state_q, state_d;
  logic [1:0]  init_cnt_q, init_cnt_d;
  logic        load_en, run_en;

  logic [3:0]  raw_in, lvl, chg;
  logic        unused_swt_chg;

  // Bit order: 0 = A, 1 = B, 2 = button, 3 = switch.
  assign raw_in = {encSWT, encBTN, encB, encA};

  for (genvar gi = 0; gi < 4; gi++) begin : g_filt
    localparam int unsigned N_CYC = (gi < 2) ? QUAD_FILTER_CYCLES : DEBOUNCE_CYCLES;
    sync_filter #(
      .N         (N_CYC),
      .RESET_VAL (1'b0)
    ) u_filt (
      .clk     (clk_100MHz),
      .rst_n   (resetn),
      .din_i   (raw_in[gi]),
      .run_i   (run_en),
      .load_i  (load_en),
      .level_o (lvl[gi]),
      .chg_o   (chg[gi])
    );
  end

  assign unused_swt_chg = chg[3];

  // Controller state register.
  always_ff @(posedge clk_100MHz or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // INIT lets the synchronizers fill, then loads the filters silently.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    load_en    = 1'b0;
    run_en     = 1'b0;
    case (state_q)
      INIT: begin
        if (init_cnt_q == 2'd3) begin
          load_en    = 1'b1;
          state_d    = RUN;
          init_cnt_d = 2'd0;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      RUN:     run_en  = 1'b1;
      default: state_d = INIT;
    endcase
  end

  // The previous quad state is recovered from the change strobes, so the
  // silent INIT load can never look like an edge.
  quad_t      quad_new, quad_old;
  logic [1:0] quad_chg;
  logic       edge_legal, edge_illegal, edge_cw;

  assign quad_new     = {lvl[0], lvl[1]};
  assign quad_chg     = {chg[0], chg[1]};
  assign quad_old     = quad_new ^ quad_chg;
  assign edge_legal   = ^quad_chg;
  assign edge_illegal = &quad_chg;
  assign edge_cw      = (quad_pos(quad_new) - quad_pos(quad_old)) == 2'd1;

  logic signed [2:0]      acc_q, acc_d;
  logic signed [3:0]      acc_sum;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;
  logic                   step_cw_q, step_cw_d;
  logic                   step_ccw_q, step_ccw_d;

  // Phase accumulation, detent counting and error tracking; clear wins.
  always_comb begin
    acc_d      = acc_q;
    count_d    = count_q;
    dir_d      = dir_q;
    err_d      = err_q;
    step_cw_d  = 1'b0;
    step_ccw_d = 1'b0;
    acc_sum    = {acc_q[2], acc_q} + (edge_cw ? 4'sd1 : -4'sd1);
    if (clr_count) begin
      acc_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (edge_illegal) begin
      err_d = 1'b1;
      acc_d = '0;
    end else if (edge_legal) begin
      if (acc_sum == ACC_POS) begin
        count_d   = count_q + COUNT_WIDTH'(1);
        step_cw_d = 1'b1;
        dir_d     = DIR_CW;
        acc_d     = '0;
      end else if (acc_sum == ACC_NEG) begin
        count_d    = count_q - COUNT_WIDTH'(1);
        step_ccw_d = 1'b1;
        dir_d      = DIR_CCW;
        acc_d      = '0;
      end else begin
        acc_d = acc_sum[2:0];
      end
    end
  end

  // Decoder registers.
  always_ff @(posedge clk_100MHz or negedge resetn) begin
    if (!resetn) begin
      acc_q      <= '0;
      count_q    <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
    end
  end

  assign count     = count_q;
  assign step_cw   = step_cw_q;
  assign step_ccw  = step_ccw_q;
  assign dir       = dir_q;
  assign err       = err_q;
  assign btn_level = lvl[2];
  assign btn_press = chg[2] & lvl[2];
  assign swt_level = lvl[3];

endmodule
